// File: rtl/conv_pkg.sv
// Shared constants and types for the 4x4 / 3x3 / 2x2 convolution sequencer.
// Holds the scratchpad memory map, the convolution geometry and the
// controller state encoding.
package conv_pkg;

  // Default widths. Instances may override them through module parameters.
  localparam int DW_DEFAULT    = 8;
  localparam int AW_DEFAULT    = 5;
  localparam int ACC_W_DEFAULT = 20;

  // Scratchpad memory map: A (input), B (kernel), C (result).
  localparam int A_BASE = 0;
  localparam int B_BASE = 16;
  localparam int C_BASE = 25;
  localparam int N_OPND = 25;

  // Convolution geometry.
  localparam int IN_DIM  = 4;
  localparam int K_DIM   = 3;
  localparam int OUT_DIM = 2;
  localparam int N_OUT   = OUT_DIM * OUT_DIM;

  // Width of the load counter, which walks the A and B regions.
  localparam int LCNT_W = $clog2(N_OPND);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    WR,
    DONE
  } state_e;

  // Flat operand index of input element A[row][col].
  function automatic int a_index(input int row, input int col);
    return A_BASE + IN_DIM * row + col;
  endfunction

  // Flat operand index of kernel element B[row][col].
  function automatic int b_index(input int row, input int col);
    return B_BASE + K_DIM * row + col;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Unsigned multiply-accumulate unit used by the convolution sequencer.
// clr has priority over en; the accumulator holds when neither is asserted.
module conv_mac #(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;

  assign prod = a_i * b_i;

  // Next accumulator value: clear, accumulate one product, or hold.
  always_comb begin
    // NOTE: acc_d gets a default first so every path assigns it and no latch is inferred.
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: loads A (4x4) and B (3x3) from the scratchpad,
// computes the 2x2 valid convolution with one MAC, and writes C back.
// A run takes a fixed 66 cycles: 25 LOAD, 4 x (9 MAC + 1 WR), 1 DONE.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int AW        = AW_DEFAULT,
  parameter int ACC_W     = ACC_W_DEFAULT,
  parameter int OUT_SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          sat_flag,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Controller state and registered outputs.
  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                sat_q;
  logic                we_q;
  logic [AW-1:0]       addr_q;

  // Sequencing counters.
  logic [LCNT_W-1:0]   load_cnt_q;
  logic [1:0]          out_idx_q;
  logic [1:0]          row_q;
  logic [1:0]          col_q;

  // Local copy of A and B, indexed by scratchpad address.
  logic [DW-1:0]       opnd_q [N_OPND];

  // Datapath signals.
  logic [LCNT_W-1:0]   a_idx;
  logic [LCNT_W-1:0]   b_idx;
  logic [DW-1:0]       mac_a;
  logic [DW-1:0]       mac_b;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_shifted;
  logic                sat;
  logic [DW-1:0]       wdata;
  logic                last_tap;

  // Operand selection for the current output pixel and kernel tap.
  always_comb begin
    a_idx = LCNT_W'(a_index(int'(out_idx_q[1]) + int'(row_q),
                            int'(out_idx_q[0]) + int'(col_q)));
    b_idx = LCNT_W'(b_index(int'(row_q), int'(col_q)));
  end

  assign mac_a    = opnd_q[a_idx];
  assign mac_b    = opnd_q[b_idx];
  assign last_tap = (row_q == 2'(K_DIM - 1)) && (col_q == 2'(K_DIM - 1));

  conv_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != MAC),
    .en_i  (state_q == MAC),
    .a_i   (mac_a),
    .b_i   (mac_b),
    .acc_o (acc)
  );

  // Output scaling: shift, then clamp to the largest DW-bit value.
  always_comb begin
    acc_shifted = acc >> OUT_SHIFT;
    sat         = |acc_shifted[ACC_W-1:DW];
    wdata       = '0;
    if (state_q == WR) begin
      wdata = sat ? '1 : acc_shifted[DW-1:0];
    end
  end

  // Operand capture during LOAD; read data is valid in the same cycle as the address.
  always_ff @(posedge clk) begin
    // NOTE: the operand array has no reset; every entry is rewritten by LOAD before any MAC reads it.
    if (!rst && state_q == LOAD) begin
      opnd_q[load_cnt_q] <= mem_rdata;
    end
  end

  // Main sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      load_cnt_q <= '0;
      out_idx_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;

      case (state_q)
        IDLE: begin
          if (start) begin
            sat_q      <= 1'b0;
            busy_q     <= 1'b1;
            load_cnt_q <= '0;
            addr_q     <= AW'(A_BASE);
            state_q    <= LOAD;
          end
        end

        LOAD: begin
          if (load_cnt_q == LCNT_W'(N_OPND - 1)) begin
            out_idx_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            state_q   <= MAC;
          end else begin
            load_cnt_q <= load_cnt_q + 1'b1;
            addr_q     <= AW'(load_cnt_q + 1'b1);
          end
        end

        MAC: begin
          if (last_tap) begin
            we_q    <= 1'b1;
            addr_q  <= AW'(C_BASE) + AW'(out_idx_q);
            state_q <= WR;
          end else if (col_q == 2'(K_DIM - 1)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end

        WR: begin
          if (sat) begin
            sat_q <= 1'b1;
          end
          if (out_idx_q == 2'(N_OUT - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            out_idx_q <= out_idx_q + 1'b1;
            row_q     <= '0;
            col_q     <= '0;
            state_q   <= MAC;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sat_flag  = sat_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed testbench for conv_seq_ctrl with a behavioural scratchpad.
// Sample index m means "sampled on the falling edge after rising edge k+m",
// where edge k accepts start; that is cycle k+m+1 in run-relative numbering.
module tb_conv_seq_ctrl;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int LOG_N = 160;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          sat_flag;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [32];

  int vectors     = 0;
  int miscompares = 0;

  // Per-run observation logs.
  int            wr_cnt;
  int            wr_m   [16];
  int            wr_a   [16];
  int            wr_d   [16];
  int            done_cnt;
  int            done_m [4];
  logic          busy_log [LOG_N];
  logic          sat_log  [LOG_N];
  int            addr_log [LOG_N];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  conv_seq_ctrl #(
    .DW        (8),
    .AW        (5),
    .ACC_W     (20),
    .OUT_SHIFT (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .sat_flag  (sat_flag),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // mode 0: A=addr+1, B=1; mode 1: A=addr+1, B center only; mode 2: all 255.
  task automatic load_mem(input int mode);
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = (mode == 2) ? 8'hFF : 8'(i + 1);
    for (int i = 16; i < 25; i++) begin
      case (mode)
        0:       mem[i] = 8'd1;
        1:       mem[i] = (i == 20) ? 8'd1 : 8'd0;
        default: mem[i] = 8'hFF;
      endcase
    end
  endtask

  // Start a run at edge k and log n_samp samples. start is re-driven
  // high for edges < hold_edge and at edges s1/s2; rst is driven at edge rst_edge.
  task automatic run(input int n_samp, input int hold_edge, input int s1,
                     input int s2, input int rst_edge);
    wr_cnt   = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int m = 0; m < n_samp; m++) begin
      @(negedge clk);
      busy_log[m] = busy;
      sat_log[m]  = sat_flag;
      addr_log[m] = int'(mem_addr);
      if (mem_we && wr_cnt < 16) begin
        wr_m[wr_cnt] = m;
        wr_a[wr_cnt] = int'(mem_addr);
        wr_d[wr_cnt] = int'(mem_wdata);
        wr_cnt++;
      end else if (mem_we) begin
        wr_cnt++;
      end
      if (done) begin
        if (done_cnt < 4) done_m[done_cnt] = m;
        done_cnt++;
      end
      start = ((m + 1) < hold_edge) || ((m + 1) == s1) || ((m + 1) == s2);
      rst   = ((m + 1) == rst_edge);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %b want 0", sat_flag); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", mem_we); end
    vectors++; if (mem_addr !== 5'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
    vectors++; if (mem_wdata !== 8'd0) begin miscompares++; $display("FAIL reset_wdata: got %0d want 0", mem_wdata); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_ramp_ones();
    int exp_c [4] = '{54, 63, 90, 99};
    load_mem(0);
    run(70, 0, -1, -1, -1);
    for (int m = 0; m < 25; m++) begin
      vectors++; if (addr_log[m] != m) begin miscompares++; $display("FAIL ramp_load_addr m=%0d: got %0d want %0d", m, addr_log[m], m); end
    end
    vectors++; if (wr_cnt != 4) begin miscompares++; $display("FAIL ramp_wr_count: got %0d want 4", wr_cnt); end
    for (int i = 0; i < 4 && i < wr_cnt; i++) begin
      vectors++; if (wr_m[i] != 34 + 10 * i) begin miscompares++; $display("FAIL ramp_wr_time%0d: got %0d want %0d", i, wr_m[i], 34 + 10 * i); end
      vectors++; if (wr_a[i] != 25 + i) begin miscompares++; $display("FAIL ramp_wr_addr%0d: got %0d want %0d", i, wr_a[i], 25 + i); end
      vectors++; if (wr_d[i] != exp_c[i]) begin miscompares++; $display("FAIL ramp_wr_data%0d: got %0d want %0d", i, wr_d[i], exp_c[i]); end
      vectors++; if (int'(mem[25 + i]) != exp_c[i]) begin miscompares++; $display("FAIL ramp_mem%0d: got %0d want %0d", 25 + i, mem[25 + i], exp_c[i]); end
    end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL ramp_done_count: got %0d want 1", done_cnt); end
    vectors++; if (done_cnt > 0 && done_m[0] != 65) begin miscompares++; $display("FAIL ramp_done_time: got %0d want 65", done_m[0]); end
    vectors++; if (busy_log[0] !== 1'b1) begin miscompares++; $display("FAIL ramp_busy_first: got %b want 1", busy_log[0]); end
    vectors++; if (busy_log[64] !== 1'b1) begin miscompares++; $display("FAIL ramp_busy_lastwr: got %b want 1", busy_log[64]); end
    vectors++; if (busy_log[65] !== 1'b0) begin miscompares++; $display("FAIL ramp_busy_done: got %b want 0", busy_log[65]); end
    vectors++; if (sat_log[69] !== 1'b0) begin miscompares++; $display("FAIL ramp_sat: got %b want 0", sat_log[69]); end
  endtask

  task automatic test_center_tap();
    int exp_c [4] = '{6, 7, 10, 11};
    load_mem(1);
    run(70, 0, -1, -1, -1);
    vectors++; if (wr_cnt != 4) begin miscompares++; $display("FAIL center_wr_count: got %0d want 4", wr_cnt); end
    for (int i = 0; i < 4 && i < wr_cnt; i++) begin
      vectors++; if (wr_m[i] != 34 + 10 * i) begin miscompares++; $display("FAIL center_wr_time%0d: got %0d want %0d", i, wr_m[i], 34 + 10 * i); end
      vectors++; if (wr_d[i] != exp_c[i]) begin miscompares++; $display("FAIL center_wr_data%0d: got %0d want %0d", i, wr_d[i], exp_c[i]); end
    end
  endtask

  task automatic test_saturate();
    load_mem(2);
    run(70, 0, -1, -1, -1);
    vectors++; if (wr_cnt != 4) begin miscompares++; $display("FAIL sat_wr_count: got %0d want 4", wr_cnt); end
    for (int i = 0; i < 4 && i < wr_cnt; i++) begin
      vectors++; if (wr_d[i] != 255) begin miscompares++; $display("FAIL sat_wr_data%0d: got %0d want 255", i, wr_d[i]); end
    end
    vectors++; if (sat_log[33] !== 1'b0) begin miscompares++; $display("FAIL sat_before_wr: got %b want 0", sat_log[33]); end
    vectors++; if (sat_log[35] !== 1'b1) begin miscompares++; $display("FAIL sat_after_wr: got %b want 1", sat_log[35]); end
    repeat (5) @(negedge clk);
    vectors++; if (sat_flag !== 1'b1) begin miscompares++; $display("FAIL sat_held_idle: got %b want 1", sat_flag); end
  endtask

  // Follows test_saturate: the start of this run must clear sat_flag.
  task automatic test_start_ignored();
    int exp_c [4] = '{54, 63, 90, 99};
    load_mem(0);
    run(70, 0, 10, 40, -1);
    vectors++; if (sat_log[0] !== 1'b0) begin miscompares++; $display("FAIL ign_sat_cleared: got %b want 0", sat_log[0]); end
    vectors++; if (wr_cnt != 4) begin miscompares++; $display("FAIL ign_wr_count: got %0d want 4", wr_cnt); end
    for (int i = 0; i < 4 && i < wr_cnt; i++) begin
      vectors++; if (wr_d[i] != exp_c[i]) begin miscompares++; $display("FAIL ign_wr_data%0d: got %0d want %0d", i, wr_d[i], exp_c[i]); end
    end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
    vectors++; if (done_cnt > 0 && done_m[0] != 65) begin miscompares++; $display("FAIL ign_done_time: got %0d want 65", done_m[0]); end
    vectors++; if (busy_log[66] !== 1'b0) begin miscompares++; $display("FAIL ign_idle_after: got %b want 0", busy_log[66]); end
  endtask

  task automatic test_rst_mid_run();
    load_mem(0);
    run(70, 0, -1, -1, 40);
    vectors++; if (wr_cnt != 1) begin miscompares++; $display("FAIL rst_wr_count: got %0d want 1", wr_cnt); end
    vectors++; if (wr_cnt > 0 && wr_m[0] != 34) begin miscompares++; $display("FAIL rst_wr_time: got %0d want 34", wr_m[0]); end
    vectors++; if (mem[25] !== 8'd54) begin miscompares++; $display("FAIL rst_mem25: got %0d want 54", mem[25]); end
    vectors++; if (mem[26] !== 8'd0) begin miscompares++; $display("FAIL rst_mem26: got %0d want 0", mem[26]); end
    vectors++; if (done_cnt != 0) begin miscompares++; $display("FAIL rst_done_count: got %0d want 0", done_cnt); end
    vectors++; if (busy_log[39] !== 1'b1) begin miscompares++; $display("FAIL rst_busy_before: got %b want 1", busy_log[39]); end
    vectors++; if (busy_log[40] !== 1'b0) begin miscompares++; $display("FAIL rst_busy_after: got %b want 0", busy_log[40]); end
    run(70, 0, -1, -1, -1);
    vectors++; if (wr_cnt != 4) begin miscompares++; $display("FAIL rst_rerun_wr_count: got %0d want 4", wr_cnt); end
    vectors++; if (mem[28] !== 8'd99) begin miscompares++; $display("FAIL rst_rerun_mem28: got %0d want 99", mem[28]); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL rst_rerun_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    load_mem(0);
    run(140, 134, -1, -1, -1);
    vectors++; if (done_cnt != 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    vectors++; if (done_cnt > 0 && done_m[0] != 65) begin miscompares++; $display("FAIL b2b_done0: got %0d want 65", done_m[0]); end
    vectors++; if (done_cnt > 1 && done_m[1] != 132) begin miscompares++; $display("FAIL b2b_done1: got %0d want 132", done_m[1]); end
    vectors++; if (wr_cnt != 8) begin miscompares++; $display("FAIL b2b_wr_count: got %0d want 8", wr_cnt); end
    vectors++; if (wr_cnt > 7 && wr_m[7] != 131) begin miscompares++; $display("FAIL b2b_last_wr: got %0d want 131", wr_m[7]); end
    vectors++; if (busy_log[65] !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_done: got %b want 0", busy_log[65]); end
    vectors++; if (busy_log[66] !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_idle: got %b want 0", busy_log[66]); end
    vectors++; if (busy_log[67] !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_rerun: got %b want 1", busy_log[67]); end
    vectors++; if (busy_log[100] !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_mid: got %b want 1", busy_log[100]); end
    vectors++; if (busy_log[134] !== 1'b0) begin miscompares++; $display("FAIL b2b_no_third: got %b want 0", busy_log[134]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    rst   = 1'b1;
    start = 1'b0;
    test_reset();
    test_ramp_ones();
    test_center_tap();
    test_saturate();
    test_start_ignored();
    test_rst_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
